uart_tx_param: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO. It accepts words over a valid/ready handshake, buffers them, and serialises each one as start bit, DATA_BITS data bits LSB first, optional parity, and STOP_BITS stop bits, with every bit held for CLKS_PER_BIT clocks. It replaces the fixed 8-bit, single-byte transmitter in the processor's I/O path and allows back-to-back frames without software pacing.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_param.sv | 152 +++++++++++++++
 tb/tb_uart_tx_param.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizes for the parametrised UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words for the UART transmitter.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_BITS,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with integrated FIFO: start, DATA_BITS LSB first, optional parity, STOP_BITS.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int PARITY_ODD   = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_BITS-1:0]            data,
    input  logic                            data_valid,
    output logic                            data_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_tx_param: illegal parameter combination");
    end

    tx_state_t            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_valid),
        .pop   (fifo_pop),
        .wdata (data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign data_ready = !fifo_full;
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign bit_end    = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= (state_q == IDLE || bit_end) ? '0 : baud_q + BAUD_W'(1);
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: fifo_pop = !fifo_empty;
            START: if (bit_end) begin
                state_d = DATA;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                if (idx_q == DATA_LAST) begin
                    idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = parity_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    tx_d  = shift_q[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (bit_end) begin
                if (idx_q == STOP_LAST) begin
                    idx_d = '0;
                    if (fifo_empty) state_d = IDLE;
                    else            fifo_pop = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Back-to-back frames reload from the FIFO without passing through IDLE.
        if (fifo_pop) begin
            state_d  = START;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
            idx_d    = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = (^fifo_rdata) ^ (PARITY_ODD != 0);
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: randomized words checked against a frame-level reference model.
module tb_uart_tx_param;

    localparam int CPB   = 4;
    localparam int D0    = 8;
    localparam int S0    = 1;
    localparam int D1    = 5;
    localparam int S1    = 2;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L0   = (1 + D0 + PAR + S0) * CPB;
    localparam int L1   = (1 + D1 + PAR + S1) * CPB;
    localparam int MAXC = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data0 = '0;
    logic       valid0 = 1'b0;
    logic       rdy0, tx0, busy0;
    logic [2:0] cnt0;
    logic [4:0] data1 = '0;
    logic       valid1 = 1'b0;
    logic       rdy1, tx1, busy1;
    logic [2:0] cnt1;

    int checks = 0;
    int errors = 0;

    // dut0 and dut1 are stepped by one edge per trace slot; slot c holds outputs after edge c.
    logic tr_tx[MAXC], tr_busy[MAXC], tr_rdy[MAXC];
    int   tr_cnt[MAXC];
    bit   exp_tx[MAXC], exp_busy[MAXC], exp_rdy[MAXC];
    int   exp_cnt[MAXC];
    logic t1_tx[MAXC], t1_busy[MAXC];
    logic [7:0] push_q[$];
    logic [7:0] acc_w[$];
    int         acc_c[$];
    int         exp_s[$];

    always #5 clk = ~clk;

    uart_tx_param #(
        .DATA_BITS(D0), .STOP_BITS(S0), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .data(data0), .data_valid(valid0),
        .data_ready(rdy0), .tx(tx0), .busy(busy0), .fifo_count(cnt0)
    );

    uart_tx_param #(
        .DATA_BITS(D1), .STOP_BITS(S1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .data(data1), .data_valid(valid1),
        .data_ready(rdy1), .tx(tx1), .busy(busy1), .fifo_count(cnt1)
    );

    // Bit at position pos of a frame: start, data LSB first, optional parity, then stop bits.
    function automatic bit frame_bit(input logic [8:0] w, input int nd, input int odd, input int pos);
        int ones;
        if (pos == 0) return 1'b0;
        if (pos <= nd) return w[pos-1];
        if (PAR == 1 && pos == nd + 1) begin
            ones = 0;
            for (int i = 0; i < nd; i++) ones += int'(w[i]);
            return ((ones % 2) == 1) ^ (odd == 1);
        end
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_run();
        push_q.delete();
        acc_w.delete();
        acc_c.delete();
    endtask

    // Drives push_q into dut0 with valid/ready handshake and records outputs for n edges.
    task automatic run(input int n);
        bit offered, rdy_now;
        for (int c = 0; c < n; c++) begin
            offered = (push_q.size() > 0);
            if (offered) data0 = push_q[0];
            valid0  = offered;
            rdy_now = rdy0;
            step();
            if (offered && rdy_now) begin
                acc_w.push_back(push_q.pop_front());
                acc_c.push_back(c);
            end
            tr_tx[c]   = tx0;
            tr_busy[c] = busy0;
            tr_rdy[c]  = rdy0;
            tr_cnt[c]  = int'(cnt0);
        end
        valid0 = 1'b0;
    endtask

    // Reference: frame k starts one edge after acceptance, or right as the previous frame ends.
    task automatic build_model(input int n);
        int prev_end, s, live;
        exp_s.delete();
        prev_end = 0;
        foreach (acc_c[k]) begin
            s = acc_c[k] + 1;
            if (s < prev_end) s = prev_end;
            exp_s.push_back(s);
            prev_end = s + L0;
        end
        for (int c = 0; c < n; c++) begin
            exp_tx[c]   = 1'b1;
            exp_busy[c] = 1'b0;
            live = 0;
            foreach (acc_c[k]) begin
                if (acc_c[k] <= c) live++;
                if (exp_s[k] <= c) live--;
                if (c >= exp_s[k] && c < exp_s[k] + L0) begin
                    exp_tx[c]   = frame_bit({1'b0, acc_w[k]}, D0, 0, (c - exp_s[k]) / CPB);
                    exp_busy[c] = 1'b1;
                end
            end
            exp_cnt[c] = live;
            exp_rdy[c] = (live < DEPTH);
        end
    endtask

    function automatic int first_diff(input int n);
        for (int c = 0; c < n; c++)
            if (tr_tx[c] !== exp_tx[c] || tr_busy[c] !== exp_busy[c] ||
                tr_cnt[c] != exp_cnt[c] || tr_rdy[c] !== exp_rdy[c]) return c;
        return -1;
    endfunction

    function automatic int ones_busy0(input int n);
        int b = 0;
        for (int c = 0; c < n; c++) b += (tr_busy[c] === 1'b1) ? 1 : 0;
        return b;
    endfunction

    // Pushes one word into dut1 and records outputs for n edges (slot 0 = push edge).
    task automatic run1(input logic [4:0] w, input int n);
        data1  = w;
        valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        t1_tx[0] = tx1;
        t1_busy[0] = busy1;
        for (int c = 1; c < n; c++) begin
            step();
            t1_tx[c]   = tx1;
            t1_busy[c] = busy1;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        repeat (3) step();
        checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL reset_tx got %b want 1", tx0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
        checks++; if (cnt0 !== 3'd0)  begin errors++; $display("FAIL reset_count got %0d want 0", cnt0); end
        checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b want 1", rdy0); end
        checks++; if (tx1 !== 1'b1 || busy1 !== 1'b0 || rdy1 !== 1'b1 || cnt1 !== 3'd0) begin
            errors++; $display("FAIL reset_dut1 got tx=%b busy=%b rdy=%b cnt=%0d want 1 0 1 0", tx1, busy1, rdy1, cnt1);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        logic [7:0] words[4];
        int n, d;
        n = L0 + 4;
        words[0] = 8'hA5;
        for (int i = 1; i < 4; i++) words[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            clear_run();
            push_q.push_back(words[i]);
            run(n);
            build_model(n);
            checks++; if (tr_cnt[0] != 1) begin errors++; $display("FAIL single_count_after_push word=%h got %0d want 1", words[i], tr_cnt[0]); end
            checks++; if (tr_tx[0] !== 1'b1 || tr_tx[1] !== 1'b0 || tr_busy[1] !== 1'b1 || tr_cnt[1] != 0) begin
                errors++; $display("FAIL single_start_latency word=%h got tx=%b%b busy=%b cnt=%0d want tx=10 busy=1 cnt=0",
                                   words[i], tr_tx[0], tr_tx[1], tr_busy[1], tr_cnt[1]);
            end
            checks++; if (ones_busy0(n) != L0) begin errors++; $display("FAIL single_busy_len word=%h got %0d want %0d", words[i], ones_busy0(n), L0); end
            d = first_diff(n);
            checks++; if (d >= 0) begin
                errors++; $display("FAIL single_trace word=%h cycle %0d got tx=%b busy=%b cnt=%0d rdy=%b want tx=%b busy=%b cnt=%0d rdy=%b",
                                   words[i], d, tr_tx[d], tr_busy[d], tr_cnt[d], tr_rdy[d], exp_tx[d], exp_busy[d], exp_cnt[d], exp_rdy[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, d;
        n = 6 * L0 + 8;
        clear_run();
        for (int i = 0; i < 6; i++) push_q.push_back(8'($urandom_range(0, 255)));
        run(n);
        build_model(n);
        checks++; if (acc_c.size() != 6) begin errors++; $display("FAIL b2b_accepted got %0d want 6", acc_c.size()); end
        if (acc_c.size() == 6) begin
            checks++; if (tr_cnt[acc_c[4]] != 4 || tr_rdy[acc_c[4]] !== 1'b0) begin
                errors++; $display("FAIL b2b_full got cnt=%0d rdy=%b want cnt=4 rdy=0", tr_cnt[acc_c[4]], tr_rdy[acc_c[4]]);
            end
            checks++; if (acc_c[5] != acc_c[0] + L0 + 2) begin
                errors++; $display("FAIL b2b_sixth_held got edge %0d want %0d", acc_c[5], acc_c[0] + L0 + 2);
            end
        end
        checks++; if (ones_busy0(n) != 6 * L0) begin errors++; $display("FAIL b2b_busy_len got %0d want %0d", ones_busy0(n), 6 * L0); end
        d = first_diff(n);
        checks++; if (d >= 0) begin
            errors++; $display("FAIL b2b_trace cycle %0d got tx=%b busy=%b cnt=%0d rdy=%b want tx=%b busy=%b cnt=%0d rdy=%b",
                               d, tr_tx[d], tr_busy[d], tr_cnt[d], tr_rdy[d], exp_tx[d], exp_busy[d], exp_cnt[d], exp_rdy[d]);
        end
    endtask

    task automatic test_mid_frame_reset();
        int n, d;
        n = 1 + 4 * CPB + 2;
        clear_run();
        for (int i = 0; i < 3; i++) push_q.push_back(8'($urandom_range(0, 255)));
        run(n);
        build_model(n);
        d = first_diff(n);
        checks++; if (d >= 0) begin
            errors++; $display("FAIL midreset_pre_trace cycle %0d got tx=%b busy=%b cnt=%0d want tx=%b busy=%b cnt=%0d",
                               d, tr_tx[d], tr_busy[d], tr_cnt[d], exp_tx[d], exp_busy[d], exp_cnt[d]);
        end
        checks++; if (tr_cnt[n-1] != 2) begin errors++; $display("FAIL midreset_queued got %0d want 2", tr_cnt[n-1]); end
        reset = 1'b1;
        step();
        checks++; if (tx0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd0 || rdy0 !== 1'b1) begin
            errors++; $display("FAIL midreset_state got tx=%b busy=%b cnt=%0d rdy=%b want 1 0 0 1", tx0, busy0, cnt0, rdy0);
        end
        reset = 1'b0;
        clear_run();
        run(2 * L0);
        build_model(2 * L0);
        d = first_diff(2 * L0);
        checks++; if (d >= 0) begin
            errors++; $display("FAIL midreset_no_frames cycle %0d got tx=%b busy=%b cnt=%0d want tx=1 busy=0 cnt=0",
                               d, tr_tx[d], tr_busy[d], tr_cnt[d]);
        end
    endtask

    task automatic test_stop2();
        logic [4:0] words[2];
        int n, bad, busy_n;
        bit e_tx, e_busy;
        n = L1 + 3;
        words[0] = 5'h1F;
        words[1] = 5'($urandom_range(0, 31));
        for (int i = 0; i < 2; i++) begin
            run1(words[i], n);
            bad = -1;
            busy_n = 0;
            for (int c = 0; c < n; c++) begin
                e_busy = (c >= 1 && c < 1 + L1);
                e_tx   = e_busy ? frame_bit({4'b0, words[i]}, D1, 1, (c - 1) / CPB) : 1'b1;
                busy_n += (t1_busy[c] === 1'b1) ? 1 : 0;
                if (bad < 0 && (t1_tx[c] !== e_tx || t1_busy[c] !== e_busy)) bad = c;
            end
            checks++; if (bad >= 0) begin
                errors++; $display("FAIL stop2_trace word=%h cycle %0d got tx=%b busy=%b", words[i], bad, t1_tx[bad], t1_busy[bad]);
            end
            checks++; if (busy_n != L1) begin errors++; $display("FAIL stop2_busy_len word=%h got %0d want %0d", words[i], busy_n, L1); end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        clear_run();
        push_q.push_back(8'h07);
        run(L0 + 4);
        checks++; if (tr_tx[1 + 9 * CPB + 1] !== 1'b1) begin
            errors++; $display("FAIL parity_even got %b want 1", tr_tx[1 + 9 * CPB + 1]);
        end
        checks++; if (ones_busy0(L0 + 4) != 44) begin errors++; $display("FAIL parity_frame_len got %0d want 44", ones_busy0(L0 + 4)); end
        run1(5'h07, L1 + 3);
        checks++; if (t1_tx[1 + 6 * CPB + 1] !== 1'b0) begin
            errors++; $display("FAIL parity_odd got %b want 0", t1_tx[1 + 6 * CPB + 1]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_mid_frame_reset();
        test_stop2();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
